// File: rtl/apu_frame_sequencer.sv
// Game Boy APU frame sequencer: divides clk down to 512 Hz frame events and
// walks an 8-step table that strobes the length, sweep and envelope units.
module apu_frame_sequencer #(
    parameter int PRESCALE = 8192
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       div_reset,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic [2:0] step,
    output logic       next_no_length
);

    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc;
    logic [2:0]    tick_q;   // {env, sweep, length}
    logic          frame_evt;

    // Strobe pattern for the step being left: {env, sweep, length}
    function automatic logic [2:0] decode_step(input logic [2:0] s);
        logic [2:0] t;
        t = 3'b000;
        case (s)
            3'd0, 3'd4: t = 3'b001;
            3'd2, 3'd6: t = 3'b011;
            3'd7:       t = 3'b100;
            default:    t = 3'b000;
        endcase
        return t;
    endfunction

    // div_reset and disable both outrank a coincident wrap
    assign frame_evt = enable && !div_reset && (presc == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc  <= '0;
            step   <= 3'd0;
            tick_q <= 3'b000;
        end else if (!enable) begin
            presc  <= '0;
            step   <= 3'd0;
            tick_q <= 3'b000;
        end else if (div_reset) begin
            presc  <= '0;
            tick_q <= 3'b000;
        end else if (frame_evt) begin
            presc  <= '0;
            step   <= step + 3'd1;
            tick_q <= decode_step(step);
        end else begin
            presc  <= presc + PW'(1);
            tick_q <= 3'b000;
        end
    end

    assign length_tick    = tick_q[0];
    assign sweep_tick     = tick_q[1];
    assign env_tick       = tick_q[2];
    assign next_no_length = step[0];

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Directed bench for apu_frame_sequencer with PRESCALE=4.
module tb_apu_frame_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       div_reset;
    logic       length_tick, sweep_tick, env_tick;
    logic [2:0] step;
    logic       next_no_length;

    int n_tests = 0;
    int n_fail  = 0;

    apu_frame_sequencer #(.PRESCALE(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .enable(enable),
        .div_reset(div_reset),
        .length_tick(length_tick),
        .sweep_tick(sweep_tick),
        .env_tick(env_tick),
        .step(step),
        .next_no_length(next_no_length)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] strobes();
        return {env_tick, sweep_tick, length_tick};
    endfunction

    // Expected {env,sweep,length} after edge e of a fresh run (table for PRESCALE=4)
    function automatic logic [2:0] exp_strobes(input int e);
        case (e % 32)
            4, 20: return 3'b001;
            12, 28: return 3'b011;
            0:  return (e > 0) ? 3'b100 : 3'b000;
            default: return 3'b000;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        enable = 1'b0;
        div_reset = 1'b0;
        #12;
        chk("rst_strobes", 32'(strobes()), 32'd0);
        chk("rst_step", 32'(step), 32'd0);
        chk("rst_nnl", 32'(next_no_length), 32'd0);

        // Fresh run: 32 edges covering a full 8-step cycle
        tick();
        rst_n = 1'b1;
        enable = 1'b1;
        for (int e = 1; e <= 32; e++) begin
            tick();
            chk($sformatf("run_strb_e%0d", e), 32'(strobes()), 32'(exp_strobes(e)));
            if (e % 4 == 0) begin
                chk($sformatf("run_step_e%0d", e), 32'(step), 32'((e / 4) % 8));
                chk($sformatf("run_nnl_e%0d", e), 32'(next_no_length), 32'((e / 4) % 2));
            end
        end
        chk("run_wrap_step", 32'(step), 32'd0);

        // div_reset coinciding with the wrap suppresses the event
        for (int i = 0; i < 3; i++) tick();
        div_reset = 1'b1;
        tick();
        div_reset = 1'b0;
        chk("divw_strb", 32'(strobes()), 32'd0);
        chk("divw_step", 32'(step), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("divw_quiet", 32'(strobes()), 32'd0);
        end
        tick();
        chk("divw_next_strb", 32'(strobes()), 32'b001);
        chk("divw_next_step", 32'(step), 32'd1);

        // Restart from step 0, then starve the prescaler with div_reset
        enable = 1'b0;
        tick();
        chk("dis_step", 32'(step), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            div_reset = (i % 3 == 2);
            tick();
            chk("starve_strb", 32'(strobes()), 32'd0);
            chk("starve_step", 32'(step), 32'd0);
        end
        div_reset = 1'b0;
        enable = 1'b0;
        tick();
        enable = 1'b1;

        // Run to step 5, drop enable one edge, re-enable
        for (int i = 0; i < 20; i++) tick();
        chk("to5_step", 32'(step), 32'd5);
        enable = 1'b0;
        tick();
        chk("drop_step", 32'(step), 32'd0);
        chk("drop_strb", 32'(strobes()), 32'd0);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reen_quiet", 32'(strobes()), 32'd0);
        end
        tick();
        chk("reen_strb", 32'(strobes()), 32'b001);

        // Disable on the wrap edge wins
        for (int i = 0; i < 3; i++) tick();
        enable = 1'b0;
        tick();
        chk("disw_strb", 32'(strobes()), 32'd0);
        chk("disw_step", 32'(step), 32'd0);
        enable = 1'b1;

        // Async reset mid-frame at step 3, prescaler 2
        for (int i = 0; i < 14; i++) tick();
        chk("pre_rst_step", 32'(step), 32'd3);
        chk("pre_rst_nnl", 32'(next_no_length), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_step", 32'(step), 32'd0);
        chk("arst_nnl", 32'(next_no_length), 32'd0);
        chk("arst_strb", 32'(strobes()), 32'd0);
        #1;
        rst_n = 1'b1;
        for (int e = 1; e <= 12; e++) begin
            tick();
            chk($sformatf("post_strb_e%0d", e), 32'(strobes()), 32'(exp_strobes(e)));
        end
        chk("post_step", 32'(step), 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
